alu_share_arbiter: RTL and testbench

// - Shares one combinational ALU between two requesters, e.g. the integer issue slot and the branch/address unit.
// - Round-robin arbitration; valid/ready handshake on each request port and on the response port.
// - Drives the ALU operand/opcode ports and registers the result in a 1-entry response buffer tagged with the requester ID.

---
 rtl/alu_share_arbiter.sv | 103 ++++++++++
 tb/tb_alu_share_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, result held in a 1-entry tagged buffer.
// Latency: 1 cycle from accept to rsp_valid; a full, undrained buffer stalls both requesters (ready low).
// Optional per-requester saturating grant counters when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_src_a,
  input  logic [DATA_WIDTH-1:0]    req0_src_b,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_src_a,
  input  logic [DATA_WIDTH-1:0]    req1_src_b,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic [DATA_WIDTH-1:0]    alu_src_a,
  output logic [DATA_WIDTH-1:0]    alu_src_b,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result,
`ifdef ALU_ARB_STATS_EN
  output logic [CNT_WIDTH-1:0]     grant_cnt0,
  output logic [CNT_WIDTH-1:0]     grant_cnt1,
`endif
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_data
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state_q, state_d;
  logic   prio_ptr;
  logic   has_winner;
  logic   winner;
  logic   can_accept;
  logic   grant;

  // Combinational arbitration; ready is held low while in reset.
  always_comb begin
    has_winner = req0_valid | req1_valid;
    winner     = req1_valid & (~req0_valid | prio_ptr);
    can_accept = (state_q == EMPTY) | rsp_ready;
    grant      = rst_n & can_accept & has_winner;
    req0_ready = grant & ~winner;
    req1_ready = grant & winner;
  end

  always_comb begin
    alu_src_a = req0_src_a;
    alu_src_b = req0_src_b;
    alu_op    = req0_op;
    if (winner) begin
      alu_src_a = req1_src_a;
      alu_src_b = req1_src_b;
      alu_op    = req1_op;
    end
  end

  always_comb begin
    state_d   = state_q;
    rsp_valid = (state_q == FULL);
    case (state_q)
      EMPTY: if (grant) state_d = FULL;
      FULL:  if (rsp_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      prio_ptr <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        rsp_data <= alu_result;
        rsp_id   <= winner;
        prio_ptr <= ~winner;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && (grant_cnt0 != {CNT_WIDTH{1'b1}})) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready && (grant_cnt1 != {CNT_WIDTH{1'b1}})) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU; stats checks only when ALU_ARB_STATS_EN is defined.
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int CW = 4;

  localparam logic [OW-1:0] OP_AND = 4'b0000;
  localparam logic [OW-1:0] OP_OR  = 4'b0001;
  localparam logic [OW-1:0] OP_ADD = 4'b0010;
  localparam logic [OW-1:0] OP_XOR = 4'b0011;
  localparam logic [OW-1:0] OP_SUB = 4'b0110;
  localparam logic [OW-1:0] OP_EQ  = 4'b1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_src_a, req0_src_b, req1_src_a, req1_src_b;
  logic [OW-1:0] req0_op, req1_op;
  logic [DW-1:0] alu_src_a, alu_src_b, alu_result;
  logic [OW-1:0] alu_op;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [DW-1:0] rsp_data;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_fn(logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_XOR:  return a ^ b;
      OP_SUB:  return a - b;
      OP_EQ:   return {{(DW-1){1'b0}}, (a == b)};
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_src_a, alu_src_b);

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src_a(req0_src_a),
    .req0_src_b(req0_src_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src_a(req1_src_a),
    .req1_src_b(req1_src_b), .req1_op(req1_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .alu_result(alu_result),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  // Push on every accepted request, pop on every consumed response; reset drops everything.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_rsp: got id=%0d data=%0h, required no response", rsp_id, rsp_data);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          if ({rsp_id, rsp_data} !== e) begin
            errors++;
            $display("FAIL sb_rsp: got id=%0d data=%0h, required id=%0d data=%0h", rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
      if (req0_valid && req0_ready) sb.push_back({1'b0, alu_fn(req0_op, req0_src_a, req0_src_b)});
      if (req1_valid && req1_ready) sb.push_back({1'b1, alu_fn(req1_op, req1_src_a, req1_src_b)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_src_a = 32'd1; req0_src_b = 32'd2;
    req1_valid = 1'b1; req1_op = OP_OR;  req1_src_a = 32'd4; req1_src_b = 32'd8;
    tick(); tick();
    mid();
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b required 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b required 0", req1_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %0h required 0", rsp_data); end
    tick();
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    tick();
    req0_valid = 1'b1; req0_op = OP_ADD; req0_src_a = 32'd5; req0_src_b = 32'd3;
    rsp_ready = 1'b1;
    mid();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready: got %b required 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_req1_ready: got %b required 0", req1_ready); end
    checks++; if (alu_op !== OP_ADD) begin errors++; $display("FAIL single_alu_op: got %0h required %0h", alu_op, OP_ADD); end
    tick();
    req0_valid = 1'b0;
    mid();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b required 1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id: got %b required 0", rsp_id); end
    checks++; if (rsp_data !== 32'd8) begin errors++; $display("FAIL single_rsp_data: got %0h required 8", rsp_data); end
  endtask

  task automatic test_contention();
    logic prev;
    tick();
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_SUB; req0_src_a = 32'd10;   req0_src_b = 32'd4;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_src_a = 32'hF0;   req1_src_b = 32'hFF;
    tick();
    rst_n = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic exp_id;
      exp_id = i[0];
      mid();
      checks++;
      if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin
        errors++;
        $display("FAIL contention_grant%0d: got ready0=%b ready1=%b required winner %0d", i, req0_ready, req1_ready, exp_id);
      end
      if (i > 0) begin
        checks++;
        if (rsp_id !== prev || rsp_data !== (prev ? 32'h0F : 32'd6)) begin
          errors++;
          $display("FAIL contention_rsp%0d: got id=%b data=%0h required id=%b data=%0h", i, rsp_id, rsp_data, prev, prev ? 32'h0F : 32'd6);
        end
      end
      prev = exp_id;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    mid();
    checks++;
    if (rsp_id !== 1'b1 || rsp_data !== 32'h0F) begin
      errors++;
      $display("FAIL contention_last: got id=%b data=%0h required id=1 data=f", rsp_id, rsp_data);
    end
  endtask

  task automatic test_backpressure();
    tick();
    req0_valid = 1'b1; req0_op = OP_AND; req0_src_a = 32'hC; req0_src_b = 32'hA;
    rsp_ready = 1'b1;
    mid();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_load_ready: got %b required 1", req0_ready); end
    tick();
    req0_valid = 1'b0; rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = OP_EQ; req1_src_a = 32'd7; req1_src_b = 32'd7;
    for (int i = 0; i < 3; i++) begin
      mid();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: got ready0=%b ready1=%b required 0 0", i, req0_ready, req1_ready);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd8) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b id=%b data=%0h required v=1 id=0 data=8", i, rsp_valid, rsp_id, rsp_data);
      end
      tick();
    end
    rsp_ready = 1'b1;
    mid();
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_load: got %b required 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    mid();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd1) begin
      errors++;
      $display("FAIL bp_eq_rsp: got v=%b id=%b data=%0h required v=1 id=1 data=1", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    req0_valid = 1'b1; req0_op = OP_ADD; req0_src_a = 32'd1; req0_src_b = 32'd1;
    rsp_ready = 1'b1;
    mid();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rmid_load_ready: got %b required 1", req0_ready); end
    tick();
    req0_valid = 1'b0; rsp_ready = 1'b0;
    mid();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd2) begin
      errors++;
      $display("FAIL rmid_full: got v=%b data=%0h required v=1 data=2", rsp_valid, rsp_data);
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_src_a = 32'd2; req0_src_b = 32'd2;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_src_a = 32'd9; req1_src_b = 32'd1;
    mid();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_dropped: got %b required 0", rsp_valid); end
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_prio: got ready0=%b ready1=%b required 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    mid();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd4) begin
      errors++;
      $display("FAIL rmid_rsp: got v=%b id=%b data=%0h required v=1 id=0 data=4", rsp_valid, rsp_id, rsp_data);
    end
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    int exp0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; rsp_ready = 1'b1;
    mid();
    checks++;
    if (grant_cnt0 !== '0 || grant_cnt1 !== '0) begin
      errors++;
      $display("FAIL stats_reset: got cnt0=%0d cnt1=%0d required 0 0", grant_cnt0, grant_cnt1);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      req0_valid = 1'b1; req0_op = OP_ADD; req0_src_a = i; req0_src_b = 32'd1;
      tick();
    end
    req0_valid = 1'b0;
    exp0 = (20 > (2**CW - 1)) ? (2**CW - 1) : 20;
    mid();
    checks++; if (grant_cnt0 !== exp0[CW-1:0]) begin errors++; $display("FAIL stats_cnt0: got %0d required %0d", grant_cnt0, exp0); end
    checks++; if (grant_cnt1 !== '0) begin errors++; $display("FAIL stats_cnt1: got %0d required 0", grant_cnt1); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    tick();
    mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending responses, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
